mux8_scan_ctrl: RTL and testbench



---
 rtl/mux8_scan_ctrl_pkg.sv | 13 +
 rtl/mux8_settle_timer.sv | 29 ++
 rtl/mux8_scan_ctrl.sv | 135 +++++++++++++
 tb/tb_mux8_scan_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mux8_scan_ctrl_pkg.sv
// Shared types and sizes for the 8:1 mux scan controller.
package mux8_scan_ctrl_pkg;

  localparam int MUX_WIDTH = 8;
  localparam int SEL_BITS  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mux8_settle_timer.sv
// Settle down-time counter: ticks on the cycle the count reaches SETTLE_CYCLES-1,
// then wraps to zero; clr holds it at zero.
module mux8_settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

  logic [3:0] count_q;

  assign tick = en && (count_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 4'd0;
    end else if (clr || tick) begin
      count_q <= 4'd0;
    end else if (en) begin
      count_q <= count_q + 4'd1;
    end
  end

endmodule

// File: rtl/mux8_scan_ctrl.sv
// Steps the 8:1 mux selects, samples Y after a settle time and presents the byte
// with valid/ready. Optional data_parity output under `MUX8_SCAN_PARITY_EN.
//
// state   | meaning
// IDLE    | waiting for start, sel held 0
// SCAN    | stepping sel 0..7, capturing Y on each settle tick
// DONE    | data_word valid, waiting for data_ready
module mux8_scan_ctrl
  import mux8_scan_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter bit          CONTINUOUS    = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mux_y,
  output logic                 sel_s1,
  output logic                 sel_s2,
  output logic                 sel_s3,
  output logic                 busy,
  output logic [MUX_WIDTH-1:0] data_word,
  output logic                 data_valid,
`ifdef MUX8_SCAN_PARITY_EN
  output logic                 data_parity,
`endif
  input  logic                 data_ready
);

  state_t                state_q, state_d;
  logic [SEL_BITS-1:0]   sel_q, sel_d;
  logic [MUX_WIDTH-1:0]  cap_q, cap_d;
  logic [MUX_WIDTH-1:0]  word_q, word_d;
  logic [MUX_WIDTH-1:0]  full_word;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  tick;
`ifdef MUX8_SCAN_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  mux8_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q != ST_SCAN),
    .en    (state_q == ST_SCAN),
    .tick  (tick)
  );

  // Bit 7 is taken straight from Y so the word loads complete on the last tick.
  assign full_word = {mux_y, cap_q[MUX_WIDTH-2:0]};

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cap_d   = cap_q;
    word_d  = word_q;
    valid_d = valid_q;
`ifdef MUX8_SCAN_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        sel_d = '0;
        if (start) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (tick) begin
          cap_d[sel_q] = mux_y;
          if (sel_q == SEL_BITS'(MUX_WIDTH - 1)) begin
            state_d = ST_DONE;
            word_d  = full_word;
            valid_d = 1'b1;
            sel_d   = '0;
`ifdef MUX8_SCAN_PARITY_EN
            parity_d = ^full_word;
`endif
          end else begin
            sel_d = sel_q + SEL_BITS'(1);
          end
        end
      end
      ST_DONE: begin
        sel_d = '0;
        if (valid_q && data_ready) begin
          valid_d = 1'b0;
          state_d = CONTINUOUS ? ST_SCAN : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      cap_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MUX8_SCAN_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cap_q   <= cap_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
`ifdef MUX8_SCAN_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign sel_s1     = sel_q[0];
  assign sel_s2     = sel_q[1];
  assign sel_s3     = sel_q[2];
  assign busy       = busy_q;
  assign data_word  = word_q;
  assign data_valid = valid_q;
`ifdef MUX8_SCAN_PARITY_EN
  assign data_parity = parity_q;
`endif

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// Scoreboard bench for mux8_scan_ctrl: three instances (settle 1, settle 3, continuous)
// each driven by a behavioural 8:1 mux.
module tb_mux8_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start    [3];
  logic       ready    [3];
  logic [7:0] mux_in   [3];
  logic       y        [3];
  logic       s1       [3];
  logic       s2       [3];
  logic       s3       [3];
  logic       busy     [3];
  logic       valid    [3];
  logic [7:0] word     [3];
  logic       parity   [3];

  int         total = 0;
  int         bad   = 0;
  logic [7:0] sb [$];
  logic [7:0] last_word;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_mux
    assign y[g] = mux_in[g][{s3[g], s2[g], s1[g]}];
`ifndef MUX8_SCAN_PARITY_EN
    assign parity[g] = 1'b0;
`endif
  end

  mux8_scan_ctrl #(.SETTLE_CYCLES(1), .CONTINUOUS(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .mux_y(y[0]),
    .sel_s1(s1[0]), .sel_s2(s2[0]), .sel_s3(s3[0]), .busy(busy[0]),
    .data_word(word[0]), .data_valid(valid[0]),
`ifdef MUX8_SCAN_PARITY_EN
    .data_parity(parity[0]),
`endif
    .data_ready(ready[0]));

  mux8_scan_ctrl #(.SETTLE_CYCLES(3), .CONTINUOUS(1'b0)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .mux_y(y[1]),
    .sel_s1(s1[1]), .sel_s2(s2[1]), .sel_s3(s3[1]), .busy(busy[1]),
    .data_word(word[1]), .data_valid(valid[1]),
`ifdef MUX8_SCAN_PARITY_EN
    .data_parity(parity[1]),
`endif
    .data_ready(ready[1]));

  mux8_scan_ctrl #(.SETTLE_CYCLES(1), .CONTINUOUS(1'b1)) u_dutc (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .mux_y(y[2]),
    .sel_s1(s1[2]), .sel_s2(s2[2]), .sel_s3(s3[2]), .busy(busy[2]),
    .data_word(word[2]), .data_valid(valid[2]),
`ifdef MUX8_SCAN_PARITY_EN
    .data_parity(parity[2]),
`endif
    .data_ready(ready[2]));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] selv(input int i);
    return {s3[i], s2[i], s1[i]};
  endfunction

  task automatic tick_edge();
    @(posedge clk);
    #1;
  endtask

  // Walk one scan from sel=0 to DONE, then check the produced word against the scoreboard.
  task automatic collect(input int i, input int settle, input bit restart_mid);
    logic [7:0] exp;
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < settle; c++) begin
        check_val($sformatf("sel%0d_k%0d", i, k), 32'(selv(i)), 32'(k));
        check_val($sformatf("novalid%0d_k%0d", i, k), 32'(valid[i]), 32'd0);
        if (restart_mid && k == 3 && c == 0) start[i] = 1'b1;
        tick_edge();
        start[i] = 1'b0;
      end
    end
    check_val($sformatf("valid%0d", i), 32'(valid[i]), 32'd1);
    if (sb.size() == 0) begin
      check_val("sb_empty", 32'd1, 32'd0);
      exp = 8'h00;
    end else begin
      exp = sb.pop_front();
    end
    last_word = exp;
    check_val($sformatf("word%0d", i), 32'(word[i]), 32'(exp));
`ifdef MUX8_SCAN_PARITY_EN
    check_val($sformatf("parity%0d", i), 32'(parity[i]), 32'(^exp));
`endif
    check_val($sformatf("sel_done%0d", i), 32'(selv(i)), 32'd0);
  endtask

  task automatic do_scan(input int i, input int settle, input logic [7:0] pattern, input bit restart_mid);
    mux_in[i] = pattern;
    sb.push_back(pattern);
    start[i] = 1'b1;
    tick_edge();
    start[i] = 1'b0;
    check_val($sformatf("busy_scan%0d", i), 32'(busy[i]), 32'd1);
    collect(i, settle, restart_mid);
  endtask

  task automatic handshake_idle(input int i);
    tick_edge();
    check_val($sformatf("hs_valid%0d", i), 32'(valid[i]), 32'd0);
    check_val($sformatf("hs_busy%0d", i), 32'(busy[i]), 32'd0);
    check_val($sformatf("hs_word%0d", i), 32'(word[i]), 32'(last_word));
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      ready[i] = 1'b0;
      mux_in[i] = 8'h00;
    end
    #12 rst_n = 1'b1;
    tick_edge();
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("rst_sel%0d", i), 32'(selv(i)), 32'd0);
      check_val($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
      check_val($sformatf("rst_valid%0d", i), 32'(valid[i]), 32'd0);
      check_val($sformatf("rst_word%0d", i), 32'(word[i]), 32'd0);
    end

    // settle 1, basic
    ready[0] = 1'b1;
    do_scan(0, 1, 8'hA5, 1'b0);
    handshake_idle(0);

    // settle 3
    ready[1] = 1'b1;
    do_scan(1, 3, 8'h5A, 1'b0);
    handshake_idle(1);

    // backpressure
    ready[0] = 1'b0;
    do_scan(0, 1, 8'h96, 1'b0);
    mux_in[0] = 8'h00;
    for (int n = 0; n < 5; n++) begin
      tick_edge();
      check_val("bp_valid", 32'(valid[0]), 32'd1);
      check_val("bp_word", 32'(word[0]), 32'h96);
      check_val("bp_sel", 32'(selv(0)), 32'd0);
      check_val("bp_busy", 32'(busy[0]), 32'd1);
    end
    ready[0] = 1'b1;
    handshake_idle(0);

    // start re-pulsed mid-scan is ignored
    do_scan(0, 1, 8'h3E, 1'b1);
    handshake_idle(0);
    tick_edge();
    check_val("no_requeue_busy", 32'(busy[0]), 32'd0);

    // async reset mid-scan
    mux_in[0] = 8'h0F;
    start[0] = 1'b1;
    tick_edge();
    start[0] = 1'b0;
    for (int n = 0; n < 40 && selv(0) != 3'd4; n++) tick_edge();
    check_val("reach_sel4", 32'(selv(0)), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_sel", 32'(selv(0)), 32'd0);
    check_val("arst_busy", 32'(busy[0]), 32'd0);
    check_val("arst_valid", 32'(valid[0]), 32'd0);
    check_val("arst_word", 32'(word[0]), 32'd0);
    #3 rst_n = 1'b1;
    tick_edge();
    check_val("post_rst_busy", 32'(busy[0]), 32'd0);
    do_scan(0, 1, 8'hFF, 1'b0);
    handshake_idle(0);

    // continuous mode: 3C then C3 then 01
    ready[2] = 1'b0;
    sb.push_back(8'h3C);
    sb.push_back(8'hC3);
    sb.push_back(8'h01);
    mux_in[2] = 8'h3C;
    start[2] = 1'b1;
    tick_edge();
    start[2] = 1'b0;
    collect(2, 1, 1'b0);
    mux_in[2] = 8'hC3;
    tick_edge();
    check_val("cont_hold_valid", 32'(valid[2]), 32'd1);
    ready[2] = 1'b1;
    tick_edge();
    check_val("cont_busy", 32'(busy[2]), 32'd1);
    collect(2, 1, 1'b0);
    mux_in[2] = 8'h01;
    tick_edge();
    collect(2, 1, 1'b0);
    ready[2] = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
